// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control and data bundle between the random word generator
// and the logic that drives it and consumes its words.
// master: stimulus/consumer side, slave: the generator.
interface lfsr_gen_if #(
   parameter int WIDTH = 32
) ();
   logic             en;
   logic             seed_load;
   logic [WIDTH-1:0] seed;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] random;
   logic [7:0]       random_lb;
   logic             wrap;
   logic [WIDTH-1:0] period;

   modport master (
      output en, seed_load, seed, out_ready,
      input  out_valid, random, random_lb, wrap, period
   );

   modport slave (
      input  en, seed_load, seed, out_ready,
      output out_valid, random, random_lb, wrap, period
   );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Galois LFSR word generator with a valid/ready
// output register, runtime seeding with zero-seed protection and optional
// period measurement.
// Optional feature macro: LFSR_PERIOD_CNT_EN (builds the start register,
// advance counter, wrap pulse and period output; otherwise wrap/period are 0).
// rst is asynchronous and active-low.
module lfsr_gen #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] TAPS       = 32'h80200003,
   parameter int               STEP       = 8,
   parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input logic        clk,
   input logic        rst,
   lfsr_gen_if.slave  bus
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   // STEP single Galois steps unrolled into one combinational advance.
   function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] v;
      v = s;
      for (int i = 0; i < STEP; i++) begin
         if (v[0]) begin
            v = {1'b0, v[WIDTH-1:1]} ^ TAPS;
         end else begin
            v = {1'b0, v[WIDTH-1:1]};
         end
      end
      return v;
   endfunction

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] random_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] next_s;
   logic [WIDTH-1:0] seed_sel_s;
   logic             adv_s;

   // A zero seed would lock the LFSR, so it is replaced by RESET_SEED.
   assign seed_sel_s = (bus.seed == ZERO) ? RESET_SEED : bus.seed;
   assign next_s     = lfsr_advance(state_r);
   // Advance only when the output register is empty or being drained.
   assign adv_s      = bus.en & ~bus.seed_load & (~out_valid_r | bus.out_ready);

   // State, output word and valid flag: seed load beats advance beats consume.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= RESET_SEED;
         random_r    <= ZERO;
         out_valid_r <= 1'b0;
      end else if (bus.seed_load) begin
         state_r     <= seed_sel_s;
         out_valid_r <= 1'b0;
      end else if (adv_s) begin
         state_r     <= next_s;
         random_r    <= next_s;
         out_valid_r <= 1'b1;
      end else if (out_valid_r && bus.out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign bus.random    = random_r;
   assign bus.out_valid = out_valid_r;

   generate
      if (WIDTH < 8) begin : g_lb_narrow
         assign bus.random_lb = {{(8-WIDTH){1'b0}}, random_r};
      end else begin : g_lb_wide
         assign bus.random_lb = random_r[7:0];
      end
   endgenerate

`ifdef LFSR_PERIOD_CNT_EN
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0] start_r;
   logic [WIDTH-1:0] cnt_r;
   logic             wrap_r;
   logic [WIDTH-1:0] period_r;

   // Period measurement: count advances until the state returns to its start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_r  <= RESET_SEED;
         cnt_r    <= ZERO;
         wrap_r   <= 1'b0;
         period_r <= ZERO;
      end else if (bus.seed_load) begin
         start_r  <= seed_sel_s;
         cnt_r    <= ZERO;
         wrap_r   <= 1'b0;
      end else if (adv_s) begin
         if (next_s == start_r) begin
            wrap_r   <= 1'b1;
            period_r <= cnt_r + ONE;
            cnt_r    <= ZERO;
         end else begin
            wrap_r   <= 1'b0;
            cnt_r    <= (cnt_r == ONES) ? cnt_r : cnt_r + ONE;
         end
      end else begin
         wrap_r   <= 1'b0;
      end
   end

   assign bus.wrap   = wrap_r;
   assign bus.period = period_r;
`else
   assign bus.wrap   = 1'b0;
   assign bus.period = ZERO;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed bench for lfsr_gen with a word scoreboard.
// dut4 uses WIDTH=4, TAPS=4'hC, STEP=1; dut32 uses the default parameters.
module tb_lfsr_gen;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   lfsr_gen_if #(.WIDTH(4))  bus4  ();
   lfsr_gen_if #(.WIDTH(32)) bus32 ();

   lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .STEP(1), .RESET_SEED(4'h1)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4));
   lfsr_gen dut32 (.clk(clk), .rst(rst), .bus(bus32));

   // reference model state
   logic [3:0]  m4_state, m4_rand, m4_start, m4_cnt, m4_period;
   logic        m4_valid, m4_wrap;
   logic [3:0]  q4[$];
   logic [31:0] m32_state, m32_rand;
   logic        m32_valid;
   logic [31:0] q32[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref4(input logic [3:0] s);
      return s[0] ? ((s >> 1) ^ 4'hC) : (s >> 1);
   endfunction

   function automatic logic [31:0] ref32(input logic [31:0] s);
      logic [31:0] v;
      v = s;
      for (int k = 0; k < 8; k++) v = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
      return v;
   endfunction

   task automatic reset_models();
      m4_state = 4'h1; m4_rand = 4'h0; m4_valid = 1'b0; m4_start = 4'h1;
      m4_cnt = 4'h0; m4_wrap = 1'b0; m4_period = 4'h0; q4.delete();
      m32_state = 32'h1; m32_rand = 32'h0; m32_valid = 1'b0; q32.delete();
   endtask

   task automatic cyc4(input logic en, input logic sl, input logic [3:0] sd, input logic rdy);
      logic [3:0] exp;
      bus4.en = en; bus4.seed_load = sl; bus4.seed = sd; bus4.out_ready = rdy;
      if (m4_valid && rdy) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $error("FAIL sb4_empty observed=%0h expected=queued word", bus4.random);
         end else begin
            exp = q4.pop_front();
            chk("xfer4", bus4.random, exp);
         end
      end
      if (sl) begin
         if (m4_valid && !rdy) void'(q4.pop_back());
         m4_state = (sd == 4'h0) ? 4'h1 : sd;
         m4_valid = 1'b0; m4_start = m4_state; m4_cnt = 4'h0; m4_wrap = 1'b0;
      end else if (en && (!m4_valid || rdy)) begin
         m4_state = ref4(m4_state);
         m4_rand = m4_state; m4_valid = 1'b1;
         q4.push_back(m4_state);
         if (m4_state == m4_start) begin
            m4_wrap = 1'b1; m4_period = m4_cnt + 4'h1; m4_cnt = 4'h0;
         end else begin
            m4_wrap = 1'b0;
            if (m4_cnt != 4'hF) m4_cnt = m4_cnt + 4'h1;
         end
      end else begin
         if (m4_valid && rdy) m4_valid = 1'b0;
         m4_wrap = 1'b0;
      end
      @(posedge clk); #1;
      chk("valid4", bus4.out_valid, m4_valid);
      chk("rand4", bus4.random, m4_rand);
      chk("lb4", bus4.random_lb, {4'h0, m4_rand});
`ifdef LFSR_PERIOD_CNT_EN
      chk("wrap4", bus4.wrap, m4_wrap);
      chk("period4", bus4.period, m4_period);
`else
      chk("wrap4_tied", bus4.wrap, 1'b0);
      chk("period4_tied", bus4.period, 4'h0);
`endif
   endtask

   task automatic cyc32(input logic en, input logic sl, input logic [31:0] sd, input logic rdy);
      logic [31:0] exp;
      bus32.en = en; bus32.seed_load = sl; bus32.seed = sd; bus32.out_ready = rdy;
      if (m32_valid && rdy) begin
         if (q32.size() == 0) begin
            checks++; errors++;
            $error("FAIL sb32_empty observed=%0h expected=queued word", bus32.random);
         end else begin
            exp = q32.pop_front();
            chk("xfer32", bus32.random, exp);
         end
      end
      if (sl) begin
         if (m32_valid && !rdy) void'(q32.pop_back());
         m32_state = (sd == 32'h0) ? 32'h1 : sd;
         m32_valid = 1'b0;
      end else if (en && (!m32_valid || rdy)) begin
         m32_state = ref32(m32_state);
         m32_rand = m32_state; m32_valid = 1'b1;
         q32.push_back(m32_state);
      end else if (m32_valid && rdy) begin
         m32_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk("valid32", bus32.out_valid, m32_valid);
      chk("lb32", bus32.random_lb, m32_rand[7:0]);
   endtask

   initial begin
      bus4.en = 1'b0; bus4.seed_load = 1'b0; bus4.seed = 4'h0; bus4.out_ready = 1'b0;
      bus32.en = 1'b0; bus32.seed_load = 1'b0; bus32.seed = 32'h0; bus32.out_ready = 1'b0;
      reset_models();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid4", bus4.out_valid, 1'b0);
      chk("rst_rand4", bus4.random, 4'h0);
      chk("rst_wrap4", bus4.wrap, 1'b0);
      chk("rst_period4", bus4.period, 4'h0);
      chk("rst_valid32", bus32.out_valid, 1'b0);
      chk("rst_rand32", bus32.random, 32'h0);
      rst = 1'b1;

      // stream a few words, then reset mid-stream
      repeat (3) cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      rst = 1'b0;
      #1;
      chk("midrst_valid4", bus4.out_valid, 1'b0);
      chk("midrst_rand4", bus4.random, 4'h0);
      reset_models();
      @(posedge clk); #1;
      rst = 1'b1;

      // full sequence from RESET_SEED
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("first_word", bus4.random, 4'hC);
      for (int i = 2; i <= 15; i++) cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("word15", bus4.random, 4'h1);
`ifdef LFSR_PERIOD_CNT_EN
      chk("wrap_on_1", bus4.wrap, 1'b1);
      chk("period_15", bus4.period, 4'hF);
`endif
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("word16", bus4.random, 4'hC);

      // backpressure holds C
      repeat (5) cyc4(1'b1, 1'b0, 4'h0, 1'b0);
      chk("stall_rand", bus4.random, 4'hC);
      chk("stall_valid", bus4.out_valid, 1'b1);
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("after_stall_6", bus4.random, 4'h6);
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("after_stall_3", bus4.random, 4'h3);

      // seed load with en and out_ready high: only the load happens
      cyc4(1'b1, 1'b1, 4'hA, 1'b1);
      chk("load_valid0", bus4.out_valid, 1'b0);
      chk("load_hold", bus4.random, 4'h3);
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("seedA_w1", bus4.random, 4'h5);
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("seedA_w2", bus4.random, 4'hE);
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("seedA_w3", bus4.random, 4'h7);

      // zero seed substitutes RESET_SEED
      cyc4(1'b1, 1'b1, 4'h0, 1'b1);
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("seed0_w1", bus4.random, 4'hC);
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("seed0_w2", bus4.random, 4'h6);

      // consume without refill, then load while a word is stalled
      cyc4(1'b0, 1'b0, 4'h0, 1'b1);
      chk("drain_valid0", bus4.out_valid, 1'b0);
      cyc4(1'b1, 1'b0, 4'h0, 1'b0);
      cyc4(1'b0, 1'b1, 4'h5, 1'b0);
      cyc4(1'b1, 1'b0, 4'h0, 1'b1);
      chk("seed5_w1", bus4.random, 4'hE);
      cyc4(1'b0, 1'b0, 4'h0, 1'b1);

      // default parameters: 100 words of 8 steps each
      cyc32(1'b1, 1'b1, 32'h974CA351, 1'b1);
      repeat (100) cyc32(1'b1, 1'b0, 32'h0, 1'b1);
      cyc32(1'b0, 1'b0, 32'h0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
